// File: rtl/fifo_pkg.sv
// Shared types and default widths for the packet FIFO and its reader.
package fifo_pkg;

    localparam int DEF_BITS  = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } rd_state_t;

endpackage

// File: rtl/fifo_pkt_out_reg.sv
// One-entry valid/ready output register with end-of-packet flag.
module fifo_pkt_out_reg
    import fifo_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [BITS-1:0] load_data,
    input  logic            load_last,
    input  logic            ready,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    output logic            out_last,
    output logic            can_load
);

    logic [BITS-1:0] data_reg;
    logic            valid_reg;
    logic            last_reg;

    assign can_load  = !valid_reg || ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign out_last  = last_reg;

    // Data is only written on a load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
            last_reg  <= load_last;
        end else if (valid_reg && ready) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed packets from a FIFO and streams the payload out
// over valid/ready, counting completed packets and zero-length headers.
module fifo_pkt_reader
    import fifo_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [BITS-1:0]  fifo_dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    output logic [BITS-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] zero_len_count
);

    rd_state_t        state_reg, state_next;
    logic [BITS-1:0]  remaining_reg, remaining_next;
    logic [CNT_W-1:0] pkt_count_reg;
    logic [CNT_W-1:0] zero_len_count_reg;

    logic pop_next;
    logic load_next;
    logic load_last_next;
    logic zero_len_next;
    logic can_load;

    fifo_pkt_out_reg #(
        .BITS(BITS)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_next),
        .load_data (fifo_dout),
        .load_last (load_last_next),
        .ready     (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .can_load  (can_load)
    );

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        pop_next       = 1'b0;
        load_next      = 1'b0;
        load_last_next = 1'b0;
        zero_len_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Header pops ignore the output register; a held word keeps presenting.
                if (en && fifo_pndng) begin
                    pop_next = 1'b1;
                    if (fifo_dout == '0) begin
                        zero_len_next = 1'b1;
                    end else begin
                        remaining_next = fifo_dout;
                        state_next     = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (fifo_pndng && can_load) begin
                    pop_next       = 1'b1;
                    load_next      = 1'b1;
                    load_last_next = (remaining_reg == BITS'(1));
                    remaining_next = remaining_reg - BITS'(1);
                    if (remaining_reg == BITS'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Nothing leaves the FIFO while reset is held.
        if (rst) begin
            pop_next  = 1'b0;
            load_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            remaining_reg      <= '0;
            pkt_count_reg      <= '0;
            zero_len_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            if (zero_len_next) begin
                zero_len_count_reg <= zero_len_count_reg + CNT_W'(1);
            end
            if (out_valid && out_ready && out_last) begin
                pkt_count_reg <= pkt_count_reg + CNT_W'(1);
            end
        end
    end

    assign fifo_pop       = pop_next;
    assign busy           = (state_reg != IDLE);
    assign pkt_count      = pkt_count_reg;
    assign zero_len_count = zero_len_count_reg;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a packet-level model predicts every
// pop and every output word, plus literal checks on each scenario.
module tb_fifo_pkt_reader;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  fifo_dout;
    logic        fifo_pndng;
    logic        fifo_pop;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] zero_len_count;

    fifo_pkt_reader #(
        .BITS  (8),
        .CNT_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_dout      (fifo_dout),
        .fifo_pndng     (fifo_pndng),
        .fifo_pop       (fifo_pop),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .pkt_count      (pkt_count),
        .zero_len_count (zero_len_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // FIFO contents and packet-level model state
    logic [7:0] fifo_q[$];
    logic [8:0] exp_q[$];
    int         gap = 0;
    int         words_left = 0;
    int         exp_pkt = 0;
    int         exp_zl = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    // per-scenario observations
    int         cyc = 0;
    int         pops = 0;
    logic [7:0] acc_data[$];
    logic       acc_last[$];
    int         acc_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cycle();
        bit         pop_s, acc_s, exp_pop, can_load;
        logic [7:0] v;
        @(negedge clk);
        fifo_pndng = (fifo_q.size() > 0) && (gap == 0);
        fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        #1;
        can_load = !out_valid || out_ready;
        if (rst) begin
            chk("pop_in_reset", fifo_pop, 0);
        end else begin
            exp_pop = fifo_pndng && ((words_left == 0) ? en : can_load);
            chk("fifo_pop", fifo_pop, exp_pop);
            chk("busy", busy, words_left != 0);
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("pkt_count", pkt_count, exp_pkt);
            chk("zero_len_count", zero_len_count, exp_zl);
            if (!out_valid) chk("out_last_idle", out_last, 0);
            if (prev_stall) begin
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                chk("out_data", out_data, exp_q[0][7:0]);
                chk("out_last", out_last, exp_q[0][8]);
            end
        end
        pop_s      = fifo_pop;
        acc_s      = out_valid && out_ready && !rst;
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
        prev_last  = out_last;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            words_left = 0;
            exp_q.delete();
            exp_pkt    = 0;
            exp_zl     = 0;
            prev_stall = 0;
        end else begin
            if (acc_s) begin
                $display("[TB] word %02h last=%0d accepted at cycle %0d", prev_data, prev_last, cyc);
                acc_data.push_back(prev_data);
                acc_last.push_back(prev_last);
                acc_cyc.push_back(cyc);
                if (exp_q.size() > 0) begin
                    if (exp_q[0][8]) exp_pkt++;
                    void'(exp_q.pop_front());
                end
            end
            if (pop_s && fifo_q.size() > 0) begin
                v = fifo_q.pop_front();
                pops++;
                if (words_left == 0) begin
                    if (v == 8'h00) exp_zl++;
                    else words_left = int'(v);
                end else begin
                    exp_q.push_back({words_left == 1, v});
                    words_left--;
                end
            end
        end
        if (gap > 0) gap--;
    endtask

    task automatic clear_stats();
        cyc  = 0;
        pops = 0;
        acc_data.delete();
        acc_last.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_zero_len_count", zero_len_count, 0);
        clear_stats();
    endtask

    int stall;
    int a2_cycles;
    int gap_busy;
    bit gap_done;

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        out_ready  = 1'b1;
        fifo_dout  = 8'h00;
        fifo_pndng = 1'b0;

        // idle with an empty FIFO
        do_reset();
        repeat (5) cycle();
        chk("t1_pops", pops, 0);
        chk("t1_valid", out_valid, 0);

        // basic three-word packet
        do_reset();
        fifo_q = '{8'h03, 8'hA1, 8'hA2, 8'hA3};
        repeat (10) cycle();
        chk("t2_pops", pops, 4);
        chk("t2_words", acc_data.size(), 3);
        if (acc_data.size() == 3) begin
            chk("t2_w0", acc_data[0], 8'hA1);
            chk("t2_w1", acc_data[1], 8'hA2);
            chk("t2_w2", acc_data[2], 8'hA3);
            chk("t2_last_pattern", {acc_last[0], acc_last[1], acc_last[2]}, 3'b001);
            chk("t2_consecutive", acc_cyc[2] - acc_cyc[0], 2);
        end
        chk("t2_pkt_count", pkt_count, 1);
        chk("t2_busy", busy, 0);

        // backpressure on the middle word
        do_reset();
        fifo_q    = '{8'h03, 8'hA1, 8'hA2, 8'hA3};
        stall     = 3;
        a2_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            out_ready = 1'b1;
            if (out_valid && out_data == 8'hA2) begin
                a2_cycles++;
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end
            end
            cycle();
        end
        out_ready = 1'b1;
        chk("t3_a2_held", a2_cycles, 4);
        chk("t3_pops", pops, 4);
        chk("t3_pkt_count", pkt_count, 1);

        // zero-length header dropped, then a one-word packet
        do_reset();
        fifo_q = '{8'h00, 8'h01, 8'h55};
        repeat (8) cycle();
        chk("t4_zero_len", zero_len_count, 1);
        chk("t4_pkt_count", pkt_count, 1);
        chk("t4_words", acc_data.size(), 1);
        if (acc_data.size() == 1) begin
            chk("t4_w0", acc_data[0], 8'h55);
            chk("t4_last", acc_last[0], 1);
        end

        // FIFO runs dry mid-packet
        do_reset();
        fifo_q   = '{8'h02, 8'hB1, 8'hB2};
        gap_done = 0;
        gap_busy = 0;
        for (int i = 0; i < 15; i++) begin
            if (pops == 2 && !gap_done) begin
                gap      = 5;
                gap_done = 1;
            end
            if (gap > 0 && busy) gap_busy++;
            cycle();
        end
        chk("t5_gap_busy", gap_busy, 5);
        chk("t5_words", acc_data.size(), 2);
        if (acc_data.size() == 2) begin
            chk("t5_w0", acc_data[0], 8'hB1);
            chk("t5_w1", acc_data[1], 8'hB2);
            chk("t5_last_pattern", {acc_last[0], acc_last[1]}, 2'b01);
            chk("t5_gap_seen", acc_cyc[1] - acc_cyc[0] > 5, 1);
        end
        chk("t5_pkt_count", pkt_count, 1);

        // reset abandons a partial packet
        do_reset();
        fifo_q = '{8'h04, 8'hC1, 8'hC2};
        repeat (6) cycle();
        chk("t6_busy_before", busy, 1);
        do_reset();
        fifo_q = '{8'h01, 8'hD1};
        repeat (8) cycle();
        chk("t6_pkt_count", pkt_count, 1);
        chk("t6_words", acc_data.size(), 1);
        if (acc_data.size() == 1) begin
            chk("t6_w0", acc_data[0], 8'hD1);
            chk("t6_last", acc_last[0], 1);
        end

        // en low blocks new headers
        do_reset();
        en     = 1'b0;
        fifo_q = '{8'h01, 8'hE1};
        repeat (4) cycle();
        chk("t7_no_pop", pops, 0);
        en = 1'b1;
        repeat (6) cycle();
        chk("t7_pops", pops, 2);
        chk("t7_pkt_count", pkt_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Drains length-prefixed packets from the read side of a flop-based FIFO (`pop`/`pndng`/`Dout` interface) and presents them on a valid/ready stream with an end-of-packet marker. Sits between a packet FIFO and a downstream consumer: it pops one header word holding the payload length, then pops exactly that many payload words and forwards them with backpressure. It also counts completed packets and dropped zero-length headers.

## Interface
- `BITS`, 8: FIFO word width, which is also the header length width.
- `CNT_W`, 16: width of the status counters.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  when high, the block may start a new packet; an in-progress packet always completes.
- `fifo_dout`  in  BITS  FIFO head word; combinational, valid while `fifo_pndng`=1.
- `fifo_pndng`  in  1  FIFO holds at least one word.
- `fifo_pop`  out  1  consume the head word at this clock edge; combinational.
- `out_data`  out  BITS  payload word, registered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word in the same cycle as `out_valid`.
- `out_last`  out  1  qualifies the final payload word of a packet.
- `busy`  out  1  state is not IDLE.
- `pkt_count`  out  CNT_W  number of packets whose last word has been accepted.
- `zero_len_count`  out  CNT_W  number of zero-length headers dropped.

## Operation
- States are IDLE and PAYLOAD. A `remaining` counter, BITS wide, tracks payload words still to pop.
- The output register is free to load (`can_load`) when `!out_valid || out_ready`.
- **IDLE**
  - When `en && fifo_pndng`: assert `fifo_pop` and capture `fifo_dout` as the header.
  - Header == 0: increment `zero_len_count` and stay in IDLE.
  - Header != 0: set `remaining` to the header value and go to PAYLOAD.
  - A header pop does not depend on `can_load`. A word still held in the output register keeps being presented.
- **PAYLOAD**
  - When `fifo_pndng && can_load`: assert `fifo_pop` and load `out_data` with `fifo_dout`.
  - On the same load: set `out_valid`=1, set `out_last` = (`remaining`==1), and decrement `remaining`.
  - If `remaining` was 1, go to IDLE.
  - Otherwise, if `out_valid && out_ready`, clear `out_valid` and `out_last`.
- `fifo_pop` is never asserted while `fifo_pndng`=0.
- `fifo_pop` is asserted in IDLE only when `en`=1.
- In PAYLOAD, `fifo_pop` is asserted only when `can_load`=1.
- `pkt_count` increments when `out_valid && out_ready && out_last`.
- Both counters wrap modulo 2^CNT_W.
- When `en` falls during PAYLOAD, the packet still completes; no new header is popped afterwards.

## Timing
- On reset, all outputs are 0: `out_data`, `out_valid`, `out_last`, `busy`, both counters, and `fifo_pop`. State is IDLE and `remaining` is 0.
- If `rst` is asserted mid-packet, the partial packet is abandoned and nothing is flushed. Words still in the FIFO are not popped during reset. After reset, the next FIFO word is interpreted as a header.
- Latency:
  - Header popped at cycle t.
  - First payload pop at the earliest at t+1.
  - `out_valid` high from t+2.
- Throughput is one payload word per cycle while `out_ready`=1 and `fifo_pndng`=1.
- An N-word packet takes N+1 pops. The next header can be popped in the cycle after the last payload pop.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable and there is no payload pop.
- Bubble: if `fifo_pndng` falls mid-packet, the block stays in PAYLOAD, `out_valid` drops after acceptance, and it resumes when `fifo_pndng` rises again.
- Header value 2^BITS−1 is legal and gives 255 words at the default width.

## Structure
- `fifo_pkg`: holds the `rd_state_t` enum {IDLE, PAYLOAD} and the default `BITS`/`CNT_W` localparams shared with the FIFO.
- Sub-module `fifo_pkt_out_reg`: holds `out_data`/`out_valid`/`out_last`. Inputs are a load strobe, data, last and ready; it outputs `can_load`.
- The FSM, `remaining` counter and status counters stay in the top module.

## Test plan
- Reset, then idle with `fifo_pndng`=0 → every output is 0 and `fifo_pop` never rises.
- FIFO holds 03,A1,A2,A3, `out_ready`=1, `en`=1 → output A1,A2,A3 on three consecutive cycles with `out_last` on A3 only. Four pops total; `pkt_count`=1; `busy` returns to 0.
- Same packet with `out_ready`=0 for 3 cycles while A2 is presented → A2 held for 4 cycles, no pop during the stall, `pkt_count`=1 at the end.
- FIFO holds 00,01,55 → `zero_len_count`=1, then a single word 55 with `out_last`=1, `pkt_count`=1.
- Packet 02,B1 then `fifo_pndng` low for 5 cycles, then B2 → B1, a gap, then B2 with `out_last`; the state stays PAYLOAD throughout the gap.
- Packet 04,C1,C2 then `rst` for one cycle; after reset the FIFO supplies 01,D1 → all outputs 0 after reset, then D1 with `out_last`, `pkt_count`=1.
